// File: rtl/anim_frame_seq.sv
`default_nettype none
// anim_frame_seq: steps a frame-mux select through 0..N-1 every hold_ticks frame_ticks.
// Optional ANIM_FRAME_SEQ_PINGPONG_EN adds forward/backward (ping-pong) playback.
module anim_frame_seq #(
  parameter int TICK_W     = 6,
  parameter int MAX_FRAMES = 5
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_tick,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
`ifdef ANIM_FRAME_SEQ_PINGPONG_EN
  input  logic              pingpong,
`endif
  input  logic [2:0]        num_frames,
  input  logic [TICK_W-1:0] hold_ticks,
  output logic [2:0]        select,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0]        NF_MAX   = 3'(MAX_FRAMES);
  localparam logic [TICK_W-1:0] TICK_ONE = TICK_W'(1);

  typedef enum logic [0:0] {IDLE = 1'b0, PLAY = 1'b1} state_t;

  state_t            state;
  logic [TICK_W-1:0] tick_cnt;
  logic [TICK_W-1:0] hold_lat;
  logic [2:0]        nf_lat;
  logic              loop_lat;
`ifdef ANIM_FRAME_SEQ_PINGPONG_EN
  logic              pp_lat;
  logic              dir;     // 1 = walking back towards frame 0
`endif

  logic [2:0]        nf_clamp;
  logic [TICK_W-1:0] hold_clamp;
  logic [2:0]        last_frame;
  logic              expire;

  always_comb begin
    nf_clamp = num_frames;
    if (num_frames == 3'd0)
      nf_clamp = 3'd1;
    else if (num_frames > NF_MAX)
      nf_clamp = NF_MAX;
  end

  assign hold_clamp = (hold_ticks == '0) ? TICK_ONE : hold_ticks;
  assign last_frame = nf_lat - 3'd1;
  assign expire     = frame_tick && (tick_cnt == hold_lat - TICK_ONE);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state    <= IDLE;
      select   <= 3'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tick_cnt <= '0;
      hold_lat <= '0;
      nf_lat   <= 3'd0;
      loop_lat <= 1'b0;
`ifdef ANIM_FRAME_SEQ_PINGPONG_EN
      pp_lat   <= 1'b0;
      dir      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (stop) begin
        // stop wins over start and over an expiring tick, in either state
        state    <= IDLE;
        select   <= 3'd0;
        busy     <= 1'b0;
        tick_cnt <= '0;
`ifdef ANIM_FRAME_SEQ_PINGPONG_EN
        dir      <= 1'b0;
`endif
      end else if (start) begin
        state    <= PLAY;
        select   <= 3'd0;
        busy     <= 1'b1;
        tick_cnt <= '0;
        hold_lat <= hold_clamp;
        nf_lat   <= nf_clamp;
        loop_lat <= loop;
`ifdef ANIM_FRAME_SEQ_PINGPONG_EN
        pp_lat   <= pingpong;
        dir      <= 1'b0;
`endif
      end else if (state == PLAY && frame_tick) begin
        if (!expire) begin
          tick_cnt <= tick_cnt + TICK_ONE;
        end else begin
          tick_cnt <= '0;
`ifdef ANIM_FRAME_SEQ_PINGPONG_EN
          if (pp_lat && dir) begin
            if (select != 3'd0) begin
              select <= select - 3'd1;
            end else if (loop_lat) begin
              dir    <= 1'b0;
              select <= 3'd1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else if (select < last_frame) begin
            select <= select + 3'd1;
          end else if (pp_lat && last_frame != 3'd0) begin
            dir    <= 1'b1;
            select <= select - 3'd1;
          end else if (loop_lat) begin
            select <= 3'd0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
`else
          if (select < last_frame) begin
            select <= select + 3'd1;
          end else if (loop_lat) begin
            select <= 3'd0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
`endif
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_anim_frame_seq.sv
`default_nettype none
// tb_anim_frame_seq: table-driven directed vectors plus hand-written done-pulse sequence.
module tb_anim_frame_seq;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       loop = 1'b0;
  logic       pingpong = 1'b0;
  logic [2:0] num_frames = 3'd0;
  logic [5:0] hold_ticks = 6'd0;
  logic [2:0] select;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  anim_frame_seq #(.TICK_W(6), .MAX_FRAMES(5)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_tick (frame_tick),
    .start      (start),
    .stop       (stop),
    .loop       (loop),
`ifdef ANIM_FRAME_SEQ_PINGPONG_EN
    .pingpong   (pingpong),
`endif
    .num_frames (num_frames),
    .hold_ticks (hold_ticks),
    .select     (select),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic       rn, tk, st, sp, lp, pp;
    logic [2:0] nf;
    logic [5:0] hd;
    logic [2:0] esel;
    logic       ebusy, edone;
  } vec_t;

  vec_t vq[$];

  task automatic v(input logic rn, tk, st, sp, lp, pp, input logic [2:0] nf,
                   input logic [5:0] hd, input logic [2:0] esel, input logic ebusy, edone);
    vec_t e;
    e.rn = rn; e.tk = tk; e.st = st; e.sp = sp; e.lp = lp; e.pp = pp;
    e.nf = nf; e.hd = hd; e.esel = esel; e.ebusy = ebusy; e.edone = edone;
    vq.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply inputs right after an edge, then sample just after the following edge.
  task automatic drive(input logic rn, tk, st, sp, lp, pp, input logic [2:0] nf,
                       input logic [5:0] hd);
    Reset_n = rn; frame_tick = tk; start = st; stop = sp; loop = lp;
    pingpong = pp; num_frames = nf; hold_ticks = hd;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    // reset then idle ticks
    v(0,0,0,0,0,0, 0,0,  0,0,0);
    v(0,0,0,0,0,0, 0,0,  0,0,0);
    v(1,1,0,0,0,0, 0,0,  0,0,0);
    v(1,1,0,0,0,0, 0,0,  0,0,0);
    // one-shot nf=5 hold=2; config inputs garbled after start must not matter
    v(1,0,1,0,0,0, 5,2,  0,1,0);
    v(1,0,0,0,1,0, 0,0,  0,1,0);
    v(1,1,0,0,1,0, 0,0,  0,1,0);
    v(1,1,0,0,1,0, 0,0,  1,1,0);
    v(1,1,0,0,1,0, 0,0,  1,1,0);
    v(1,1,0,0,1,0, 0,0,  2,1,0);
    v(1,1,0,0,1,0, 0,0,  2,1,0);
    v(1,1,0,0,1,0, 0,0,  3,1,0);
    v(1,1,0,0,1,0, 0,0,  3,1,0);
    v(1,1,0,0,1,0, 0,0,  4,1,0);
    v(1,1,0,0,1,0, 0,0,  4,1,0);
    v(1,1,0,0,1,0, 0,0,  4,0,1);
    v(1,1,0,0,0,0, 0,0,  4,0,0);
    // stop in IDLE clears select
    v(1,0,0,1,0,0, 0,0,  0,0,0);
    // loop with clamp: nf=7 -> 5, hold=1
    v(1,0,1,0,1,0, 7,1,  0,1,0);
    for (int i = 1; i <= 12; i++)
      v(1,1,0,0,1,0, 7,1,  3'(i % 5),1,0);
    // stop leg
    v(1,0,1,0,0,0, 5,1,  0,1,0);
    v(1,1,0,0,0,0, 5,1,  1,1,0);
    v(1,1,0,0,0,0, 5,1,  2,1,0);
    v(1,1,0,0,0,0, 5,1,  3,1,0);
    v(1,0,0,1,0,0, 5,1,  0,0,0);
    v(1,0,0,0,0,0, 5,1,  0,0,0);
    // restart leg, hold=3: restart at select=2 with tick_cnt=2
    v(1,0,1,0,0,0, 5,3,  0,1,0);
    for (int i = 1; i <= 8; i++)
      v(1,1,0,0,0,0, 5,3,  3'(i / 3),1,0);
    v(1,0,1,0,0,0, 5,3,  0,1,0);
    v(1,1,0,0,0,0, 5,3,  0,1,0);
    v(1,1,0,0,0,0, 5,3,  0,1,0);
    v(1,1,0,0,0,0, 5,3,  1,1,0);
    // start+stop while playing: stop wins; ticks afterwards do nothing
    v(1,0,1,1,0,0, 5,3,  0,0,0);
    v(1,1,0,0,0,0, 5,3,  0,0,0);
    // stop on expiring last-frame tick: no done
    v(1,0,1,0,0,0, 2,1,  0,1,0);
    v(1,1,0,0,0,0, 2,1,  1,1,0);
    v(1,1,0,1,0,0, 2,1,  0,0,0);
    v(1,0,0,0,0,0, 2,1,  0,0,0);
    // start coinciding with expiring tick: start wins
    v(1,0,1,0,0,0, 3,1,  0,1,0);
    v(1,1,0,0,0,0, 3,1,  1,1,0);
    v(1,1,1,0,0,0, 3,1,  0,1,0);
    v(1,1,0,0,0,0, 3,1,  1,1,0);
    // reset mid-play at select=3
    v(1,0,1,0,1,0, 5,1,  0,1,0);
    v(1,1,0,0,1,0, 5,1,  1,1,0);
    v(1,1,0,0,1,0, 5,1,  2,1,0);
    v(1,1,0,0,1,0, 5,1,  3,1,0);
    v(0,1,0,0,1,0, 5,1,  0,0,0);
    v(1,1,0,0,1,0, 5,1,  0,0,0);
    // nf=0 -> 1, hold=0 -> 1: one-shot completes on the first tick
    v(1,0,1,0,0,0, 0,0,  0,1,0);
    v(1,1,0,0,0,0, 0,0,  0,0,1);
    v(1,0,0,0,0,0, 0,0,  0,0,0);
`ifdef ANIM_FRAME_SEQ_PINGPONG_EN
    // ping-pong one-shot nf=3: 0,1,2,1,0 then done
    v(1,0,1,0,0,1, 3,1,  0,1,0);
    v(1,1,0,0,0,0, 3,1,  1,1,0);
    v(1,1,0,0,0,0, 3,1,  2,1,0);
    v(1,1,0,0,0,0, 3,1,  1,1,0);
    v(1,1,0,0,0,0, 3,1,  0,1,0);
    v(1,1,0,0,0,0, 3,1,  0,0,1);
    // ping-pong loop nf=3: 0,1,2,1,0,1,2
    v(1,0,1,0,1,1, 3,1,  0,1,0);
    v(1,1,0,0,1,1, 3,1,  1,1,0);
    v(1,1,0,0,1,1, 3,1,  2,1,0);
    v(1,1,0,0,1,1, 3,1,  1,1,0);
    v(1,1,0,0,1,1, 3,1,  0,1,0);
    v(1,1,0,0,1,1, 3,1,  1,1,0);
    v(1,1,0,0,1,1, 3,1,  2,1,0);
    v(1,0,0,1,0,0, 3,1,  0,0,0);
`endif

    @(posedge Clk);
    #1;
    foreach (vq[i]) begin
      drive(vq[i].rn, vq[i].tk, vq[i].st, vq[i].sp, vq[i].lp, vq[i].pp, vq[i].nf, vq[i].hd);
      chk($sformatf("select[%0d]", i), int'(select), int'(vq[i].esel));
      chk($sformatf("busy[%0d]", i),   int'(busy),   int'(vq[i].ebusy));
      chk($sformatf("done[%0d]", i),   int'(done),   int'(vq[i].edone));
    end

    // Hand-written: one-shot nf=4 hold=2 with a tick every cycle; wait for done with a budget.
    begin
      int  cyc;
      bool_loop: begin end
      drive(1,0,1,0,0,0, 3'd4, 6'd2);
      cyc = 0;
      while (!done && cyc < 20) begin
        drive(1,1,0,0,0,0, 3'd4, 6'd2);
        cyc++;
        if (done && busy) chk("done_with_busy", 1, 0);
      end
      chk("oneshot_ticks_to_done", cyc, 8);
      chk("oneshot_final_select", int'(select), 3);
      drive(1,1,0,0,0,0, 3'd4, 6'd2);
      chk("done_width", int'(done), 0);
      chk("idle_select_hold", int'(select), 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/anim_frame_seq.md
Name: anim_frame_seq

Overview:
- Animation frame sequencer that drives the 3-bit select of the 16-bit five-way sprite/frame mux downstream. That mux maps selects 000–011 to frames 0–3; any select of 100 or above maps to frame 4.
- Steps through frames 0..N-1 at a programmable rate, counted in frame_tick pulses (one pulse per video frame, derived from vsync).
- Supports one-shot and looping playback, restart and stop.
- Sits between the game-logic FSM (start/stop/config) and the frame mux select.

Parameters:
- TICK_W, 6, width of hold_ticks and of the internal tick counter.
- MAX_FRAMES, 5, number of mux inputs; upper clamp for num_frames.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  synchronous active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- start  in  1  one-cycle pulse; begin or restart playback at frame 0.
- stop  in  1  one-cycle pulse; abort playback.
- loop  in  1  1 = wrap to frame 0 after the last frame; 0 = one-shot.
- num_frames  in  3  frames in the sequence. 0 is treated as 1; values above MAX_FRAMES are clamped to MAX_FRAMES.
- hold_ticks  in  TICK_W  frame_ticks per frame. 0 is treated as 1.
- select  out  3  frame index to the mux, always in the range 0..MAX_FRAMES-1.
- busy  out  1  high while in PLAY.
- done  out  1  one-cycle pulse at one-shot completion.

Behaviour:
- Clock and reset: one clock (Clk); reset is synchronous and active-low (Reset_n). All state updates on the rising edge of Clk.
- Reset (Reset_n=0 at an edge):
  - state=IDLE, select=0, busy=0, done=0, tick_cnt=0, all latched configuration cleared.
  - Reset overrides every other input, including mid-playback; no done pulse is produced.
- FSM states are IDLE and PLAY.
- IDLE:
  - select holds its last value; busy=0.
  - start=1 and stop=0 -> PLAY.
  - On that transition: select=0, tick_cnt=0. Clamped num_frames, clamped hold_ticks and loop are latched into internal registers.
  - Input changes after the latch have no effect until the next start.
- PLAY:
  - busy=1.
  - On each frame_tick, tick_cnt increments.
  - When frame_tick=1 and tick_cnt==hold_latched-1, the frame expires: tick_cnt=0 and select advances on the next edge. Latency is one cycle from the expiring tick to the new select.
  - Expiry with select < nf_latched-1: select+1.
  - Expiry with select == nf_latched-1 and loop_latched=1: select=0, stay in PLAY, no done.
  - Expiry with select == nf_latched-1 and loop_latched=0:
    - next state IDLE; select holds the last frame.
    - busy=0 and done=1 in that same next cycle; done deasserts after exactly one cycle.
- stop=1 in PLAY -> IDLE next cycle with select=0, tick_cnt=0, done=0. stop in IDLE clears select to 0.
- start=1 in PLAY (restart): select=0, tick_cnt=0, configuration re-latched, stays in PLAY, no done.
- Simultaneous events:
  - start and stop in the same cycle: stop wins.
  - start coinciding with an expiring tick: start wins; the expiry is discarded.
  - stop coinciding with an expiring tick: stop wins; no done.
- Edge cases:
  - nf_latched=1: select stays 0. A one-shot completes after hold_latched ticks.
  - hold_ticks=0 is treated as 1, so the frame advances on every tick.
  - The tick counter never wraps past hold_latched-1.
- done is never asserted while busy=1.

Optional Feature:
- Macro ANIM_FRAME_SEQ_PINGPONG_EN.
- When defined:
  - Adds input port pingpong (1 bit), latched at start like the other configuration inputs.
  - With pingpong=1, the sequence runs forward to nf-1, then backward to 0, without repeating the end frames. Example for nf=3: 0,1,2,1,0.
  - One-shot completion (done, return to IDLE) occurs on expiry of frame 0 on the backward pass. With loop=1 it turns forward again: 0,1,2,1,0,1,2,...
  - With nf=1 the behaviour is identical to forward mode.
  - A direction register is cleared on start, stop and reset.
- When undefined: no pingpong port, no direction register; forward-only behaviour exactly as described above.

Test Plan:
- Reset then idle: Reset_n low 2 cycles, then high -> select=0, busy=0, done=0. frame_ticks with no start leave select=0.
- One-shot: num_frames=5, hold_ticks=2, loop=0, start -> select sequence 0,1,2,3,4, advancing one cycle after every 2nd tick. After the 10th tick: busy=0, done=1 for exactly 1 cycle, select stays 4.
- Loop and clamp: num_frames=7 (clamped to 5), hold_ticks=1, loop=1, start, 12 ticks -> select 0,1,2,3,4,0,1,2,3,4,0,1,2. No done; busy stays 1.
- Stop and restart:
  - Stop leg: start, advance to select=3, stop -> next cycle select=0, busy=0, no done.
  - Restart leg: start at select=2 -> select=0, tick_cnt reset; the next advance occurs only after a full hold_ticks.
- Collisions: start and stop in the same cycle while playing -> IDLE, select=0. Stop on the expiring last-frame tick (loop=0) -> no done pulse.
- Reset mid-play: Reset_n low while select=3 -> next cycle select=0, busy=0, done=0. With ANIM_FRAME_SEQ_PINGPONG_EN, pingpong=1, num_frames=3, hold=1, loop=0 -> select 0,1,2,1,0, then done.
